// File: rtl/input_debounce.sv
// input_debounce: two-flop synchronizer, prescaled sampler and N-sample debounce per input bit.
// Define INPUT_DEBOUNCE_EDGE_EN to add registered one-cycle rise/fall pulses per bit.
module input_debounce #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned N     = 4,
    parameter int unsigned RATE  = 125000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             sample_tick
`ifdef INPUT_DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    localparam int unsigned   CW       = (RATE > 1) ? $clog2(RATE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RATE - 1);

    logic [CW-1:0]           cnt;
    logic [WIDTH-1:0]        sync1;
    logic [WIDTH-1:0]        sync2;
    logic [WIDTH-1:0][N-1:0] hist;
    logic                    sample_c;
    logic [WIDTH-1:0]        out_next_c;

    // The edge that sees the last prescaler count is a sample edge; RATE=1 samples every edge.
    assign sample_c = (cnt == CNT_LAST);

    // Output follows a unanimous history, otherwise holds its level.
    always_comb begin
        out_next_c = out;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (&hist[i]) begin
                out_next_c[i] = 1'b1;
            end else if (~|hist[i]) begin
                out_next_c[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            sync1       <= '0;
            sync2       <= '0;
            hist        <= '0;
            out         <= '0;
            sample_tick <= 1'b0;
        end else begin
            sync1       <= in;
            sync2       <= sync1;
            cnt         <= sample_c ? '0 : cnt + CW'(1);
            sample_tick <= sample_c;
            out         <= out_next_c;
            if (sample_c) begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    hist[i] <= {hist[i][N-2:0], sync2[i]};
                end
            end
        end
    end

`ifdef INPUT_DEBOUNCE_EDGE_EN
    // Pulses coincide with the edge on which out itself changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= out_next_c & ~out;
            fall <= ~out_next_c & out;
        end
    end
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Scoreboard bench for input_debounce: RATE=4/N=4 main instance plus a RATE=1/N=2 instance.
// Stimulus pushes hand-derived per-cycle expectations; a negedge monitor pops and compares.
module tb_input_debounce;

    localparam int unsigned W = 13;
`ifdef INPUT_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] in;
    logic [W-1:0] out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         sample_tick;
    logic [W-1:0] in2;
    logic [W-1:0] out2;
    logic [W-1:0] rise2;
    logic [W-1:0] fall2;
    logic         tick2;

    input_debounce #(.WIDTH(W), .N(4), .RATE(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in(in),
        .out(out),
        .sample_tick(sample_tick)
`ifdef INPUT_DEBOUNCE_EDGE_EN
        ,
        .rise(rise),
        .fall(fall)
`endif
    );

    input_debounce #(.WIDTH(W), .N(2), .RATE(1)) dut_fast (
        .clk(clk),
        .rst_n(rst_n),
        .in(in2),
        .out(out2),
        .sample_tick(tick2)
`ifdef INPUT_DEBOUNCE_EDGE_EN
        ,
        .rise(rise2),
        .fall(fall2)
`endif
    );

`ifndef INPUT_DEBOUNCE_EDGE_EN
    assign rise  = '0;
    assign fall  = '0;
    assign rise2 = '0;
    assign fall2 = '0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        int           sid;
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         tick;
        logic [W-1:0] out2;
        logic [W-1:0] rise2;
        logic         tick2;
    } exp_t;

    exp_t q[$];
    exp_t mr;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   base = 0;
    int   sid = 0;

    logic [W-1:0] e_out  = '0;
    logic [W-1:0] e_rise = '0;
    logic [W-1:0] e_fall = '0;
    logic [W-1:0] e_out2 = '0;
    logic [W-1:0] e_rise2 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected response for the edge just taken; rst_n still holds the level that edge saw.
    task automatic push();
        exp_t r;
        r.cyc = cyc;
        r.sid = sid;
        if (!rst_n) begin
            base    = cyc;
            r.out   = '0;
            r.rise  = '0;
            r.fall  = '0;
            r.tick  = 1'b0;
            r.out2  = '0;
            r.rise2 = '0;
            r.tick2 = 1'b0;
        end else begin
            r.out   = e_out;
            r.rise  = e_rise;
            r.fall  = e_fall;
            r.tick  = (((cyc - base) % 4) == 0) && (cyc != base);
            r.out2  = e_out2;
            r.rise2 = e_rise2;
            r.tick2 = 1'b1;
        end
        q.push_back(r);
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            push();
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            mr = q.pop_front();
            checks++;
            if (mr.cyc != cyc) begin
                failures++;
                $display("FAIL s%0d stale_expectation cyc=%0d now=%0d", mr.sid, mr.cyc, cyc);
            end else begin
                if (out !== mr.out || sample_tick !== mr.tick ||
                    (EDGE_EN && (rise !== mr.rise || fall !== mr.fall))) begin
                    failures++;
                    $display("FAIL s%0d main cyc=%0d out=%h rise=%h fall=%h tick=%b required out=%h rise=%h fall=%h tick=%b",
                             mr.sid, cyc, out, rise, fall, sample_tick, mr.out, mr.rise, mr.fall, mr.tick);
                end
                checks++;
                if (out2 !== mr.out2 || tick2 !== mr.tick2 || (EDGE_EN && rise2 !== mr.rise2)) begin
                    failures++;
                    $display("FAIL s%0d fast cyc=%0d out=%h rise=%h tick=%b required out=%h rise=%h tick=%b",
                             mr.sid, cyc, out2, rise2, tick2, mr.out2, mr.rise2, mr.tick2);
                end
            end
        end
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL watchdog cyc=%0d required completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        in    = '0;
        in2   = '0;

        // s0: reset state over three edges
        sid = 0;
        adv(3);

        // s1: step on bit 0 before edge 1; samples at 4,8,12,16, out at 17
        sid = 1;
        rst_n = 1'b1;
        in    = 13'h0001;
        adv(16);
        e_out  = 13'h0001;
        e_rise = 13'h0001;
        adv(1);
        e_rise = '0;
        adv(1);

        // s2: bit 0 low for only three sample periods
        sid = 2;
        in = '0;
        adv(12);
        in = 13'h0001;
        adv(10);

        // s3: toggle every 2 cycles; phase chosen so every sample aliases to the high level
        sid = 3;
        for (int k = 0; k < 39; k++) begin
            adv(1);
            if (((cyc - base) % 4) == 1) in[0] = 1'b1;
            else if (((cyc - base) % 4) == 3) in[0] = 1'b0;
        end

        // s4: settle low, then all bits step high together, then all low
        sid = 4;
        adv(17);
        e_out  = '0;
        e_fall = 13'h0001;
        adv(1);
        e_fall = '0;
        adv(3);
        in = 13'h1FFF;
        adv(16);
        e_out  = 13'h1FFF;
        e_rise = 13'h1FFF;
        adv(1);
        e_rise = '0;
        adv(3);
        in = '0;
        adv(16);
        e_out  = '0;
        e_fall = 13'h1FFF;
        adv(1);
        e_fall = '0;
        adv(3);

        // s5: one-edge reset after three of four high samples discards the history
        sid = 5;
        in = 13'h0001;
        adv(13);
        rst_n = 1'b0;
        adv(1);
        rst_n = 1'b1;
        adv(16);
        e_out  = 13'h0001;
        e_rise = 13'h0001;
        adv(1);
        e_rise = '0;
        adv(2);

        // s6: RATE=1, N=2 instance, out[3] rises on the fifth edge after the step
        sid = 6;
        in2 = 13'h0008;
        adv(4);
        e_out2  = 13'h0008;
        e_rise2 = 13'h0008;
        adv(1);
        e_rise2 = '0;
        adv(2);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
